ce_phase_gen: RTL and testbench
===============================

# ce_phase_gen

Parametrised successor to the Vector-06C clock-enable generator. Runs in the 24 MHz domain and produces the phased pixel/CPU/video clock enables from a free-running master counter. Adds NACC run-time-programmable fractional phase accumulators for the PAL subcarrier and audio/codec clock derivation, a startup hold, and a freeze input. Sits between the PLL wrapper and the video, CPU and audio blocks.

## Interface

- CTR_WIDTH, 6, master counter width; must be ≥ 5. MSB drives pipe_ab.
- INIT_HOLD, 3, cycles after reset before the counter starts; range 0..31.
- NACC, 2, number of phase-accumulator channels; range 1..4.
- ACC_WIDTH, 32, accumulator and delta width; range 8..32.

Ports:

- clk24  in  1  24 MHz master clock. Only clock in the block.
- reset_n  in  1  Asynchronous, active-low reset.
- hold  in  1  Freezes the master counter and suppresses the CEs.
- delta_we  in  1  Write strobe for an accumulator delta.
- delta_sel  in  2  Channel index for delta_we.
- delta_data  in  ACC_WIDTH  Delta value to write.
- ce12, ce6, ce6x, ce3, ce1m5  out  1 each  Registered clock enables.
- video_slice  out  1  Registered; high when the video owns the memory slice.
- pipe_ab  out  1  Registered pipe A/B select.
- running  out  1  High once the startup hold has expired.
- ctr_q  out  CTR_WIDTH  Current master counter value.
- acc_tick  out  NACC  Registered per-channel carry-out strobe.
- acc_sq  out  NACC  Per-channel accumulator MSB (square wave).

## Operation

- Reset (asynchronous) clears:
  - the counter, the init counter, all accumulators and all deltas;
  - every output to 0, including video_slice.
- Startup:
  - The init counter counts 0..INIT_HOLD−1. The master counter does not advance and all outputs stay 0.
  - running rises on the cycle the init counter reaches INIT_HOLD.
  - With INIT_HOLD = 0, running is 1 on the first clock edge after reset release.
- When running and hold = 0, each cycle:
  - ctr increments and wraps modulo 2^CTR_WIDTH.
  - Outputs are registered from the pre-increment value c:
    - ce12 = c[0]
    - ce6 = c[1]&c[0]
    - ce6x = c[1]&~c[0]
    - ce3 = (c[2:0] == 3'b110)
    - ce1m5 = (c[3:0] == 4'b0110)
    - video_slice = ~c[2]
    - pipe_ab = c[CTR_WIDTH−1]
- When running and hold = 1:
  - ctr stays frozen.
  - On the next edge all five CEs are forced to 0; video_slice and pipe_ab keep their last value.
  - When hold is released, the sequence resumes from the frozen ctr with no skipped value.
- Accumulators:
  - Channel i computes acc[i] <= acc[i] + delta[i], modulo 2^ACC_WIDTH, every cycle once running. Accumulation ignores hold.
  - acc_tick[i] is the registered carry-out of that add.
  - acc_sq[i] = acc[i][ACC_WIDTH−1].
  - The mean tick frequency is 24 MHz × delta / 2^ACC_WIDTH.
- Delta write:
  - On delta_we with delta_sel < NACC: delta[sel] <= delta_data and acc[sel] <= 0 in the same cycle. The write wins over that cycle's accumulate, and acc_tick[sel] is 0 for that cycle.
  - A delta_sel ≥ NACC write is ignored.
  - Writes are accepted during the startup hold. Accumulation still begins only with running.
- Delta 0 keeps its channel silent (acc_tick = 0, acc_sq = 0).

## Timing

- All outputs are registered. A CE pulse is exactly one clk24 cycle wide.
- Period from counter start: ce12 every 2 cycles, ce6/ce6x every 4, ce3 every 8, ce1m5 every 16, pipe_ab every 2^CTR_WIDTH.
- Output latency is 1 cycle from the counter value.
- The first active cycle has c = 0, so ce12 = 0 and video_slice = 1 appear one edge after running rises.
- ce6x precedes ce6 by exactly 1 cycle.
- A delta write at edge N: the channel's first add uses the new delta at edge N+1.
- Reset asserted mid-operation clears everything immediately, without waiting for an edge. Startup repeats on release.

## Configuration

- CE_PHASE_GEN_ACC_EN defined: the accumulators, delta registers and write port are built as described.
- Not defined:
  - no accumulator logic is built;
  - acc_tick and acc_sq are tied to 0;
  - delta_we, delta_sel and delta_data are ignored.
- The CE generator behaves identically in both cases.

## Test plan

- Reset, then release with INIT_HOLD = 3 → all outputs 0 for 3 edges; running = 1 at edge 3; video_slice = 1 at edge 4; ce12 first high at edge 5.
- Free run for 64 cycles, CTR_WIDTH = 6 →
  - ce12 count 32, ce6 16, ce6x 16, ce3 8, ce1m5 4;
  - ce3 coincides with ctr_q − 1 = 6 mod 8;
  - pipe_ab toggles every 32 cycles.
- Assert hold for 10 cycles at ctr_q = 13 → ctr_q stays 13; CEs are 0 from the next edge; after release, ce6x asserts on the c = 14 cycle.
- Write delta 0x8000_0000 to channel 0 (ACC_WIDTH = 32) → acc_tick[0] pulses every 2nd cycle and acc_sq[0] toggles each cycle. Then write 0x4000_0000 → the accumulator is cleared and ticks come every 4 cycles.
- delta_we with delta_sel = 3 and NACC = 2 → no delta or accumulator changes; assert with the macro undefined → acc_tick = acc_sq = 0 always.
- Drop reset_n between edges mid-run → all outputs 0 immediately, without a clock edge; the full startup sequence repeats on release.

Source files
------------

// File: rtl/ce_phase_gen.sv
// ce_phase_gen: phased clock-enable generator for the 24 MHz domain.
// A free-running master counter produces the pixel/CPU/video enables. The
// counter starts after a short startup hold and can be frozen with `hold`.
// When the CE_PHASE_GEN_ACC_EN macro is defined, NACC programmable fractional
// phase accumulators are also built. They derive the subcarrier and audio
// clocks. When the macro is undefined, acc_tick/acc_sq are tied to 0.
module ce_phase_gen #(
  parameter int CTR_WIDTH = 6,   // >= 5; MSB drives pipe_ab
  parameter int INIT_HOLD = 3,   // 0..31 startup cycles
  parameter int NACC      = 2,   // 1..4 accumulator channels
  parameter int ACC_WIDTH = 32   // 8..32
) (
  input  logic                 clk24,
  input  logic                 reset_n,
  input  logic                 hold,
  input  logic                 delta_we,
  input  logic [1:0]           delta_sel,
  input  logic [ACC_WIDTH-1:0] delta_data,
  output logic                 ce12,
  output logic                 ce6,
  output logic                 ce6x,
  output logic                 ce3,
  output logic                 ce1m5,
  output logic                 video_slice,
  output logic                 pipe_ab,
  output logic                 running,
  output logic [CTR_WIDTH-1:0] ctr_q,
  output logic [NACC-1:0]      acc_tick,
  output logic [NACC-1:0]      acc_sq
);

  localparam logic [5:0] HOLD_END = 6'(INIT_HOLD);

  logic [4:0] init_cnt;
  logic [5:0] init_nxt;

  assign init_nxt = {1'b0, init_cnt} + 6'd1;

  // Startup hold: count edges after reset release until INIT_HOLD is reached.
  always_ff @(posedge clk24 or negedge reset_n) begin
    if (!reset_n) begin
      init_cnt <= '0;
      running  <= 1'b0;
    end else if (!running) begin
      // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
      init_cnt <= init_nxt[4:0];
      running  <= (init_nxt >= HOLD_END);
    end
  end

  // Master counter and CE decode, registered from the pre-increment value.
  always_ff @(posedge clk24 or negedge reset_n) begin
    if (!reset_n) begin
      ctr_q       <= '0;
      ce12        <= 1'b0;
      ce6         <= 1'b0;
      ce6x        <= 1'b0;
      ce3         <= 1'b0;
      ce1m5       <= 1'b0;
      video_slice <= 1'b0;
      pipe_ab     <= 1'b0;
    end else if (running) begin
      if (!hold) begin
        ctr_q       <= ctr_q + CTR_WIDTH'(1);
        ce12        <= ctr_q[0];
        ce6         <= ctr_q[1] & ctr_q[0];
        ce6x        <= ctr_q[1] & ~ctr_q[0];
        ce3         <= (ctr_q[2:0] == 3'b110);
        ce1m5       <= (ctr_q[3:0] == 4'b0110);
        video_slice <= ~ctr_q[2];
        pipe_ab     <= ctr_q[CTR_WIDTH-1];
      end else begin
        // Frozen: CEs drop, the slice/pipe selects keep their last phase.
        ce12  <= 1'b0;
        ce6   <= 1'b0;
        ce6x  <= 1'b0;
        ce3   <= 1'b0;
        ce1m5 <= 1'b0;
      end
    end
  end

`ifdef CE_PHASE_GEN_ACC_EN
  logic [ACC_WIDTH-1:0] acc   [NACC];
  logic [ACC_WIDTH-1:0] delta [NACC];
  logic [ACC_WIDTH:0]   sum   [NACC];

  // Per-channel widened add; the extra MSB is the carry reported as acc_tick.
  always_comb begin
    for (int i = 0; i < NACC; i++) begin
      sum[i] = {1'b0, acc[i]} + {1'b0, delta[i]};
    end
  end

  // Accumulate once running; a delta write restarts its channel from zero.
  always_ff @(posedge clk24 or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: these small register arrays are reset element by element because their cleared state is architectural; large RAMs are normally left unreset.
      for (int i = 0; i < NACC; i++) begin
        acc[i]   <= '0;
        delta[i] <= '0;
      end
      acc_tick <= '0;
    end else begin
      for (int i = 0; i < NACC; i++) begin
        if (delta_we && (int'(delta_sel) == i)) begin
          delta[i]    <= delta_data;
          acc[i]      <= '0;
          acc_tick[i] <= 1'b0;
        end else if (running) begin
          acc[i]      <= sum[i][ACC_WIDTH-1:0];
          acc_tick[i] <= sum[i][ACC_WIDTH];
        end else begin
          acc_tick[i] <= 1'b0;
        end
      end
    end
  end

  // Square-wave output is the accumulator MSB.
  always_comb begin
    // NOTE: assign a default before the loop so no bit can hold its value and infer a latch.
    acc_sq = '0;
    for (int i = 0; i < NACC; i++) begin
      acc_sq[i] = acc[i][ACC_WIDTH-1];
    end
  end
`else
  logic unused_acc_inputs;

  assign unused_acc_inputs = ^{delta_we, delta_sel, delta_data};
  assign acc_tick          = '0;
  assign acc_sq            = '0;
`endif

endmodule

// File: tb/tb_ce_phase_gen.sv
// Testbench for ce_phase_gen. The stimulus process drives inputs on the
// falling edge. It advances a behavioural model, computed from counts and
// modular arithmetic, and queues the outputs expected after the next rising
// edge. A monitor pops and compares them just after each rising edge.
module tb_ce_phase_gen;

  localparam int CTR_WIDTH = 6;
  localparam int INIT_HOLD = 3;
  localparam int NACC      = 2;
  localparam int ACC_WIDTH = 32;
  localparam int CTR_MOD   = 1 << CTR_WIDTH;
  localparam longint unsigned ACC_MOD = 64'd1 << ACC_WIDTH;

  logic                 clk24 = 1'b0;
  logic                 reset_n;
  logic                 hold;
  logic                 delta_we;
  logic [1:0]           delta_sel;
  logic [ACC_WIDTH-1:0] delta_data;
  logic                 ce12, ce6, ce6x, ce3, ce1m5;
  logic                 video_slice, pipe_ab, running;
  logic [CTR_WIDTH-1:0] ctr_q;
  logic [NACC-1:0]      acc_tick, acc_sq;

  ce_phase_gen #(
    .CTR_WIDTH(CTR_WIDTH), .INIT_HOLD(INIT_HOLD), .NACC(NACC), .ACC_WIDTH(ACC_WIDTH)
  ) dut (
    .clk24(clk24), .reset_n(reset_n), .hold(hold),
    .delta_we(delta_we), .delta_sel(delta_sel), .delta_data(delta_data),
    .ce12(ce12), .ce6(ce6), .ce6x(ce6x), .ce3(ce3), .ce1m5(ce1m5),
    .video_slice(video_slice), .pipe_ab(pipe_ab), .running(running),
    .ctr_q(ctr_q), .acc_tick(acc_tick), .acc_sq(acc_sq)
  );

  always #5 clk24 = ~clk24;

  typedef struct packed {
    logic                 running;
    logic [CTR_WIDTH-1:0] ctr;
    logic [4:0]           ces;   // {ce12, ce6, ce6x, ce3, ce1m5}
    logic                 vs;
    logic                 pipe;
    logic [NACC-1:0]      tick;
    logic [NACC-1:0]      sq;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model state: count of active cycles, startup count, held selects.
  bit              m_running;
  int              m_init;
  int              m_c;
  bit              m_vs, m_pipe;
  bit [4:0]        m_ces;
  longint unsigned m_acc   [NACC];
  longint unsigned m_delta [NACC];
  bit [NACC-1:0]   m_tick;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic model_reset();
    m_running = 0; m_init = 0; m_c = 0; m_vs = 0; m_pipe = 0; m_ces = '0; m_tick = '0;
    for (int i = 0; i < NACC; i++) begin
      m_acc[i] = 0;
      m_delta[i] = 0;
    end
  endtask

  // Advance the model by one rising edge with the given inputs.
  task automatic model_edge(input bit h, input bit we, input bit [1:0] sel,
                            input logic [ACC_WIDTH-1:0] d);
    bit was_running;
    longint unsigned s;
    was_running = m_running;
    if (!was_running) begin
      m_init++;
      if (m_init >= INIT_HOLD) m_running = 1;
      m_ces = '0;
    end else if (!h) begin
      m_ces[4] = (m_c % 2) == 1;
      m_ces[3] = (m_c % 4) == 3;
      m_ces[2] = (m_c % 4) == 2;
      m_ces[1] = (m_c % 8) == 6;
      m_ces[0] = (m_c % 16) == 6;
      m_vs     = (m_c % 8) < 4;
      m_pipe   = m_c >= (CTR_MOD / 2);
      m_c      = (m_c + 1) % CTR_MOD;
    end else begin
      m_ces = '0;
    end
`ifdef CE_PHASE_GEN_ACC_EN
    for (int i = 0; i < NACC; i++) begin
      if (we && int'(sel) == i) begin
        m_delta[i] = longint'(d);
        m_acc[i]   = 0;
        m_tick[i]  = 0;
      end else if (was_running) begin
        s          = m_acc[i] + m_delta[i];
        m_tick[i]  = s >= ACC_MOD;
        m_acc[i]   = s % ACC_MOD;
      end else begin
        m_tick[i]  = 0;
      end
    end
`endif
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.running = m_running;
    e.ctr     = CTR_WIDTH'(m_c);
    e.ces     = m_ces;
    e.vs      = m_vs;
    e.pipe    = m_pipe;
    e.tick    = m_tick;
    for (int i = 0; i < NACC; i++) e.sq[i] = m_acc[i] >= (ACC_MOD / 2);
    return e;
  endfunction

  // One cycle of stimulus: called at a falling edge, returns at the next one.
  task automatic step(input bit h, input bit we, input bit [1:0] sel,
                      input logic [ACC_WIDTH-1:0] d);
    hold = h; delta_we = we; delta_sel = sel; delta_data = d;
    model_edge(h, we, sel, d);
    exp_q.push_back(model_out());
    @(negedge clk24);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ces"}, {ce12, ce6, ce6x, ce3, ce1m5}, 0);
    chk({tag, "_vs_pipe"}, {video_slice, pipe_ab}, 0);
    chk({tag, "_running"}, running, 0);
    chk({tag, "_ctr"}, ctr_q, 0);
    chk({tag, "_acc"}, {acc_tick, acc_sq}, 0);
  endtask

  // Drop reset between edges, confirm the immediate clear, release on a falling edge.
  task automatic mid_run_reset();
    #3 reset_n = 1'b0;
    #1 chk_all_zero("async_reset");
    model_reset();
    @(negedge clk24);
    @(negedge clk24);
    reset_n = 1'b1;
  endtask

  task automatic random_steps(input int n);
    logic [ACC_WIDTH-1:0] d;
    for (int k = 0; k < n; k++) begin
      case ($urandom_range(0, 3))
        0:       d = '0;
        1:       d = ACC_WIDTH'(32'h8000_0000 >> $urandom_range(0, 4));
        default: d = ACC_WIDTH'($urandom);
      endcase
      step($urandom_range(0, 9) == 0, $urandom_range(0, 15) == 0,
           2'($urandom_range(0, 3)), d);
    end
  endtask

  // Monitor: compare every queued expectation just after the rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk24);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("running", running, e.running);
        chk("ctr_q", ctr_q, e.ctr);
        chk("ces", {ce12, ce6, ce6x, ce3, ce1m5}, e.ces);
        chk("video_slice", video_slice, e.vs);
        chk("pipe_ab", pipe_ab, e.pipe);
        chk("acc_tick", acc_tick, e.tick);
        chk("acc_sq", acc_sq, e.sq);
      end
    end
  end

  initial begin
    int guard;
    hold = 0; delta_we = 0; delta_sel = '0; delta_data = '0;
    reset_n = 1'b1;
    model_reset();
    #1 reset_n = 1'b0;
    #1 chk_all_zero("initial_reset");
    @(negedge clk24);
    reset_n = 1'b1;

    // Startup and free run past a full counter wrap.
    repeat (75) step(0, 0, 2'd0, '0);

    // Freeze at ctr_q = 13 for 10 cycles, then resume.
    guard = 0;
    while (m_c != 13 && guard < 100) begin
      step(0, 0, 2'd0, '0);
      guard++;
    end
    chk("reach_ctr13", m_c, 13);
    repeat (10) step(1, 0, 2'd0, '0);
    repeat (6) step(0, 0, 2'd0, '0);

    // Accumulator programming, including an out-of-range channel write.
    step(0, 1, 2'd0, ACC_WIDTH'(32'h8000_0000));
    repeat (8) step(0, 0, 2'd0, '0);
    step(0, 1, 2'd0, ACC_WIDTH'(32'h4000_0000));
    repeat (10) step(0, 0, 2'd0, '0);
    step(0, 1, 2'd1, ACC_WIDTH'(32'h1234_5678));
    repeat (6) step(0, 0, 2'd0, '0);
    step(0, 1, 2'd3, ACC_WIDTH'(32'hFFFF_FFFF));
    repeat (6) step(1, 0, 2'd0, '0);

    random_steps(2000);

    // Reset mid-run, with a delta written during the startup hold.
    mid_run_reset();
    step(0, 1, 2'd1, ACC_WIDTH'(32'hC000_0000));
    repeat (20) step(0, 0, 2'd0, '0);
    random_steps(600);

    hold = 0; delta_we = 0;
    @(posedge clk24);
    #2;
    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
